// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first. Two-flop synchroniser, falling-edge start
// detect and a per-frame baud counter that samples each bit at mid-bit.
module uart_rx #(
  parameter int unsigned CLK_HZ       = 200_000_000,
  parameter int unsigned BAUD         = 9600,
  parameter int unsigned BAUD_DIVISOR = CLK_HZ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BAUD_DIVISOR - 1);
  localparam logic [CNT_W-1:0] HALF   = CNT_W'(BAUD_DIVISOR / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic             rxd_m;
  logic             rxd_s;
  logic             rxd_q;
  logic [CNT_W-1:0] cntr;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             start_edge;
  logic             tick;

  // Only a high-to-low transition starts a frame; a line held low never retriggers.
  assign start_edge = rxd_q & ~rxd_s;
  assign tick       = (cntr == '0) && (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_q <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_q <= rxd_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cntr         <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
      if (state != IDLE) begin
        cntr <= tick ? RELOAD : cntr - CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (start_edge) begin
            state   <= START;
            cntr    <= HALF;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (!rxd_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shreg   <= {rxd_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          // Return to IDLE at mid-stop-bit so a back-to-back start edge is caught.
          if (tick) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
            if (rxd_s) begin
              rx_data <= shreg;
              rx_done <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed frames plus randomized streams checked
// against a byte-level expectation queue.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned DIV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       rxd4 = 1'b1;
  logic [7:0] rx_data, rx_data4;
  logic       rx_done, rx_done4;
  logic       rx_frame_err, rx_frame_err4;
  logic       rx_busy, rx_busy4;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;

  logic [7:0]  got_q[$];
  int unsigned got_t[$];
  logic [7:0]  got4_q[$];
  int unsigned ferr_n = 0;
  int unsigned ferr4_n = 0;
  int unsigned viol = 0;
  logic        prev_strobe = 1'b0;

  uart_rx #(.BAUD_DIVISOR(DIV)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_data(rx_data), .rx_done(rx_done),
    .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
  );

  uart_rx #(.BAUD_DIVISOR(4)) dut4 (
    .clk(clk), .rst(rst), .rxd(rxd4), .rx_data(rx_data4), .rx_done(rx_done4),
    .rx_frame_err(rx_frame_err4), .rx_busy(rx_busy4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record strobes away from the active edge.
  always @(negedge clk) begin
    if (rx_done) begin
      got_q.push_back(rx_data);
      got_t.push_back(cyc);
    end
    if (rx_frame_err) ferr_n++;
    if ((rx_done && rx_frame_err) || ((rx_done || rx_frame_err) && prev_strobe)) viol++;
    prev_strobe = rx_done | rx_frame_err;
    if (rx_done4) got4_q.push_back(rx_data4);
    if (rx_frame_err4) ferr4_n++;
  end

  task automatic clear_mon();
    got_q.delete();
    got_t.delete();
    got4_q.delete();
    ferr_n = 0;
    ferr4_n = 0;
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
    total++; if (rx_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", rx_done); end
    total++; if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", rx_frame_err); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    int unsigned t0;
    logic [7:0] d = 8'hA5;
    clear_mon();
    @(negedge clk);
    t0 = cyc;
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL single_busy_pre: got %b want 0", rx_busy); end
    @(negedge clk);
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL single_busy_edge: got %b want 1", rx_busy); end
    repeat (DIV - 3) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(1'b1);
    repeat (4) @(negedge clk);
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      total++; if (got_q[0] !== d) begin bad++; $display("FAIL single_data: got %h want %h", got_q[0], d); end
      total++; if (got_t[0] - t0 != 155) begin bad++; $display("FAIL single_latency: got %0d want 155", got_t[0] - t0); end
    end
    total++; if (ferr_n != 0) begin bad++; $display("FAIL single_ferr: got %0d want 0", ferr_n); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL single_busy_post: got %b want 0", rx_busy); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    @(negedge clk);
    drive_frame(8'h00, 1'b1);
    drive_frame(8'hFF, 1'b1);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", got_q.size()); end
    if (got_q.size() == 2) begin
      total++; if (got_q[0] !== 8'h00) begin bad++; $display("FAIL b2b_first: got %h want 00", got_q[0]); end
      total++; if (got_q[1] !== 8'hFF) begin bad++; $display("FAIL b2b_second: got %h want ff", got_q[1]); end
      total++; if (got_t[1] - got_t[0] != 160) begin bad++; $display("FAIL b2b_spacing: got %0d want 160", got_t[1] - got_t[0]); end
    end
    total++; if (ferr_n != 0) begin bad++; $display("FAIL b2b_ferr: got %0d want 0", ferr_n); end
  endtask

  task automatic test_glitch();
    clear_mon();
    @(negedge clk);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_edge: got %b want 1", rx_busy); end
    @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL glitch_done: got %0d want 0", got_q.size()); end
    total++; if (ferr_n != 0) begin bad++; $display("FAIL glitch_ferr: got %0d want 0", ferr_n); end
    total++; if (rx_data !== 8'hFF) begin bad++; $display("FAIL glitch_data: got %h want ff", rx_data); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy: got %b want 0", rx_busy); end
  endtask

  task automatic test_frame_err();
    clear_mon();
    @(negedge clk);
    drive_frame(8'h3C, 1'b0);
    rxd = 1'b0;
    repeat (40 * DIV) @(negedge clk);
    total++; if (ferr_n != 1) begin bad++; $display("FAIL ferr_count: got %0d want 1", ferr_n); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL ferr_done: got %0d want 0", got_q.size()); end
    total++; if (rx_data !== 8'hFF) begin bad++; $display("FAIL ferr_data: got %h want ff", rx_data); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL ferr_busy: got %b want 0", rx_busy); end
    rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    drive_frame(8'h5A, 1'b1);
    repeat (10) @(negedge clk);
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL ferr_next_count: got %0d want 1", got_q.size()); end
    if (got_q.size() == 1) begin
      total++; if (got_q[0] !== 8'h5A) begin bad++; $display("FAIL ferr_next_data: got %h want 5a", got_q[0]); end
    end
    total++; if (ferr_n != 1) begin bad++; $display("FAIL ferr_next_ferr: got %0d want 1", ferr_n); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d = 8'h81;
    clear_mon();
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rxd = d[4];
    repeat (11) @(negedge clk);
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_pre: got %b want 1", rx_busy); end
    #1 rst = 1'b1;
    #1;
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rstmid_data: got %h want 00", rx_data); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", rx_busy); end
    total++; if (rx_done !== 1'b0 || rx_frame_err !== 1'b0) begin
      bad++; $display("FAIL rstmid_strobes: got %b%b want 00", rx_done, rx_frame_err);
    end
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    total++; if (got_q.size() != 0 || ferr_n != 0) begin
      bad++; $display("FAIL rstmid_discard: got %0d/%0d want 0/0", got_q.size(), ferr_n);
    end
    drive_frame(8'h42, 1'b1);
    repeat (10) @(negedge clk);
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL rstmid_next_count: got %0d want 1", got_q.size()); end
    if (got_q.size() == 1) begin
      total++; if (got_q[0] !== 8'h42) begin bad++; $display("FAIL rstmid_next_data: got %h want 42", got_q[0]); end
    end
  endtask

  // Random bytes with random stop-bit validity; expectations built at byte level.
  task automatic test_random16();
    logic [7:0] exp_q[$];
    int unsigned exp_ferr = 0;
    logic [7:0] d;
    logic stop;
    clear_mon();
    @(negedge clk);
    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      if (stop) exp_q.push_back(d); else exp_ferr++;
      drive_frame(d, stop);
      rxd = 1'b1;
      repeat ($urandom_range(2, 40)) @(negedge clk);
    end
    repeat (DIV) @(negedge clk);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd16_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd16_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    total++; if (ferr_n != exp_ferr) begin bad++; $display("FAIL rnd16_ferr: got %0d want %0d", ferr_n, exp_ferr); end
    total++; if (viol != 0) begin bad++; $display("FAIL strobe_protocol: got %0d want 0", viol); end
  endtask

  // Divisor-4 receiver fed with asynchronous bit timing within +/-3%.
  task automatic test_random4_drift();
    logic [7:0] exp_q[$];
    logic [9:0] f;
    logic [7:0] d;
    real bit_ns;
    clear_mon();
    for (int n = 0; n < 256; n++) begin
      d = 8'($urandom);
      exp_q.push_back(d);
      bit_ns = 40.0 * (1.0 + (real'($urandom_range(0, 60)) - 30.0) / 1000.0);
      f = {1'b1, d, 1'b0};
      rxd4 = 1'b1;
      repeat ($urandom_range(2, 8)) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        rxd4 = f[i];
        #(bit_ns);
      end
    end
    rxd4 = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (got4_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd4_count: got %0d want %0d", got4_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got4_q.size(); i++) begin
      total++; if (got4_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd4_byte%0d: got %h want %h", i, got4_q[i], exp_q[i]); end
    end
    total++; if (ferr4_n != 0) begin bad++; $display("FAIL rnd4_ferr: got %0d want 0", ferr4_n); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_random16();
    test_random4_drift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
